// File: rtl/ram_stream_port_if.sv
// Bundle of the command, byte-stream and RAM signals of ram_stream_port.
// The DUT takes the slave view; the host/RAM side takes the master view.
interface ram_stream_port_if #(
   parameter int AW       = 8,
   parameter int LenWidth = 16
);
   logic                start_i;
   logic                mode_i;
   logic [AW-1:0]       base_i;
   logic [LenWidth-1:0] len_i;
   logic                busy_o;
   logic                done_o;
   logic                in_valid_i;
   logic [7:0]          in_data_i;
   logic                in_ready_o;
   logic                out_valid_o;
   logic [7:0]          out_data_o;
   logic                out_ready_i;
   logic [3:0]          ram_wr_en_o;
   logic [AW-1:0]       ram_addr_o;
   logic [31:0]         ram_wr_data_o;
   logic [31:0]         ram_rd_data_i;

   modport slave (
      input  start_i, mode_i, base_i, len_i,
      input  in_valid_i, in_data_i, out_ready_i, ram_rd_data_i,
      output busy_o, done_o, in_ready_o, out_valid_o, out_data_o,
      output ram_wr_en_o, ram_addr_o, ram_wr_data_o
   );

   modport master (
      output start_i, mode_i, base_i, len_i,
      output in_valid_i, in_data_i, out_ready_i, ram_rd_data_i,
      input  busy_o, done_o, in_ready_o, out_valid_o, out_data_o,
      input  ram_wr_en_o, ram_addr_o, ram_wr_data_o
   );
endinterface

// File: rtl/ram_stream_port.sv
// Byte-stream initiator for a single-port word RAM: LOAD writes a byte stream
// little-endian into RAM, DUMP reads words back out as a byte stream.
module ram_stream_port #(
   parameter int Words    = 256,
   parameter int LenWidth = 16
) (
   input logic clk_i,
   input logic reset_i,
   ram_stream_port_if.slave bus
);
   localparam int AW      = $clog2(Words);
   localparam int SW      = ((LenWidth > AW) ? LenWidth : AW) + 1;
   localparam bit IsPow2  = (Words == (1 << AW));

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RD_REQ  = 3'd2,
      S_RD_WAIT = 3'd3,
      S_SEND    = 3'd4
   } state_t;

   state_t              r_state,   w_state_next;
   logic [AW-1:0]       r_base,    w_base_next;
   logic [LenWidth-1:0] r_len,     w_len_next;
   logic [LenWidth-1:0] r_k,       w_k_next;
   logic [31:0]         r_buf,     w_buf_next;
   logic                r_done,    w_done_next;
   logic [3:0]          r_wr_en,   w_wr_en_next;
   logic [AW-1:0]       r_addr,    w_addr_next;
   logic [31:0]         r_wr_data, w_wr_data_next;

   logic [LenWidth-1:0] w_k_inc;
   logic [7:0]          w_lane [4];

   // Word address of byte k relative to base, wrapping modulo Words.
   function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base,
                                             input logic [LenWidth-1:0] k);
      logic [SW-1:0] sum;
      sum = SW'(base) + SW'(k >> 2);
      if (IsPow2) begin
         return sum[AW-1:0];
      end
      return AW'(sum % SW'(Words));
   endfunction

   assign w_k_inc = r_k + LenWidth'(1);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = r_buf[8*gi +: 8];
   end

   always_comb begin
      w_state_next   = r_state;
      w_base_next    = r_base;
      w_len_next     = r_len;
      w_k_next       = r_k;
      w_buf_next     = r_buf;
      w_done_next    = 1'b0;
      w_wr_en_next   = 4'b0000;
      w_addr_next    = r_addr;
      w_wr_data_next = r_wr_data;

      unique case (r_state)
         S_IDLE: begin
            if (bus.start_i) begin
               w_base_next = bus.base_i;
               w_len_next  = bus.len_i;
               w_k_next    = '0;
               if (bus.len_i == '0) begin
                  w_done_next = 1'b1;
               end else if (!bus.mode_i) begin
                  w_state_next = S_LOAD;
               end else begin
                  w_state_next = S_RD_REQ;
                  w_addr_next  = addr_of(bus.base_i, '0);
               end
            end
         end

         S_LOAD: begin
            if (bus.in_valid_i) begin
               w_wr_en_next   = 4'b0001 << r_k[1:0];
               w_addr_next    = addr_of(r_base, r_k);
               w_wr_data_next = {4{bus.in_data_i}};
               w_k_next       = w_k_inc;
               if (w_k_inc == r_len) begin
                  w_state_next = S_IDLE;
                  w_done_next  = 1'b1;
               end
            end
         end

         S_RD_REQ: begin
            w_state_next = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            w_buf_next   = bus.ram_rd_data_i;
            w_state_next = S_SEND;
         end

         S_SEND: begin
            if (bus.out_ready_i) begin
               w_k_next = w_k_inc;
               if (w_k_inc == r_len) begin
                  w_state_next = S_IDLE;
                  w_done_next  = 1'b1;
               end else if (w_k_inc[1:0] == 2'b00) begin
                  w_state_next = S_RD_REQ;
                  w_addr_next  = addr_of(r_base, w_k_inc);
               end
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= S_IDLE;
         r_base    <= '0;
         r_len     <= '0;
         r_k       <= '0;
         r_buf     <= '0;
         r_done    <= 1'b0;
         r_wr_en   <= 4'b0000;
         r_addr    <= '0;
         r_wr_data <= '0;
      end else begin
         r_state   <= w_state_next;
         r_base    <= w_base_next;
         r_len     <= w_len_next;
         r_k       <= w_k_next;
         r_buf     <= w_buf_next;
         r_done    <= w_done_next;
         r_wr_en   <= w_wr_en_next;
         r_addr    <= w_addr_next;
         r_wr_data <= w_wr_data_next;
      end
   end

   // Stream-side controls decode straight from the state register.
   assign bus.busy_o        = (r_state != S_IDLE);
   assign bus.done_o        = r_done;
   assign bus.in_ready_o    = (r_state == S_LOAD);
   assign bus.out_valid_o   = (r_state == S_SEND);
   assign bus.out_data_o    = (r_state == S_SEND) ? w_lane[r_k[1:0]] : 8'h00;
   assign bus.ram_wr_en_o   = r_wr_en;
   assign bus.ram_addr_o    = r_addr;
   assign bus.ram_wr_data_o = r_wr_data;
endmodule

// File: doc/ram_stream_port.md
Name: ram_stream_port

Overview:
- Byte-stream initiator for the single-port synchronous word RAM. The RAM has byte write enables, 1-cycle registered read, and returns 0 on any write cycle.
- LOAD mode: accepts a valid/ready byte stream, for example from the UART receiver, and writes each byte into RAM little-endian via one-hot byte enables.
- DUMP mode: reads RAM words back and emits them as a little-endian valid/ready byte stream toward the UART transmitter.
- Used for program load and memory readback over the serial link.

Parameters:
- Words, 256, RAM depth in 32-bit words; word address width AW = $clog2(Words).
- LenWidth, 16, width of the byte-count field.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  start command; sampled only in IDLE
- mode_i  in  1  0 = LOAD, 1 = DUMP; sampled with start_i
- base_i  in  AW  starting word address; sampled with start_i
- len_i  in  LenWidth  transfer length in bytes; sampled with start_i
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle completion pulse
- in_valid_i  in  1  load byte valid
- in_data_i  in  8  load byte
- in_ready_o  out  1  load byte ready
- out_valid_o  out  1  dump byte valid
- out_data_o  out  8  dump byte
- out_ready_i  in  1  dump byte ready
- ram_wr_en_o  out  4  RAM byte write enables
- ram_addr_o  out  AW  RAM word address
- ram_wr_data_o  out  32  RAM write data
- ram_rd_data_i  in  32  RAM read data, valid the cycle after the address is sampled with wr_en = 0

Behaviour:
- One clock; reset is synchronous and active-high on reset_i.
- Reset, including mid-operation: state IDLE; all outputs 0; internal counters cleared. No RAM write occurs in the cycle after reset asserts.
- States: IDLE, LOAD, RD_REQ, RD_WAIT, SEND.

IDLE:
- start_i = 1: capture base_i, len_i and mode_i; clear byte index k.
- len_i = 0: assert done_o next cycle, stay IDLE, no RAM access.
- Otherwise go to LOAD (mode 0) or RD_REQ (mode 1).

LOAD:
- in_ready_o = 1 combinationally.
- On a handshake for byte k, the next cycle's registered outputs are:
  - ram_addr_o = (base + k/4) mod Words
  - ram_wr_en_o = one-hot 1 << (k mod 4)
  - ram_wr_data_o = byte replicated into all four lanes
- ram_wr_en_o returns to 0 in any cycle not following a handshake.
- Throughput is 1 byte per cycle.
- After the handshake of byte len-1: go to IDLE. done_o pulses in the same cycle as that final write.

DUMP:
- RD_REQ: ram_addr_o = (base + k/4) mod Words, ram_wr_en_o = 0; next state RD_WAIT.
- RD_WAIT: latch ram_rd_data_i into the word buffer; next state SEND.
- SEND:
  - out_valid_o = 1, out_data_o = buffer[8*(k mod 4) +: 8].
  - out_valid_o and out_data_o hold stable until out_ready_i.
  - On each handshake, k increments.
  - If k reaches len: go to IDLE and pulse done_o in the next cycle.
  - Else if the new k mod 4 = 0: go to RD_REQ.
- ram_wr_en_o is 0 throughout DUMP.
- out_valid_o is 0 outside SEND.

General rules:
- A partial final word emits only the remaining bytes.
- Word address wraps modulo Words; k is unsigned LenWidth bits.
- in_ready_o = 0 outside LOAD; out_valid_o = 0 outside SEND.
- start_i while busy is ignored; parameters latched at start stay fixed for the whole transfer.
- done_o and start_i never overlap in effect. A start_i in the cycle done_o is high, with state already IDLE, is accepted.

Test Plan:
1. Load, base 0x10, len 5, bytes AA BB CC DD EE back-to-back:
   - Writes, in order: (0x10, 0001), (0x10, 0010), (0x10, 0100), (0x10, 1000), (0x11, 0001).
   - Data 0xAAAAAAAA, 0xBBBBBBBB, … on consecutive cycles.
   - done_o coincides with the last write.
2. Dump, base 0x10, len 5, after test 1, out_ready_i toggling 1/0:
   - Emits AA BB CC DD EE in order with stalls honoured, and exactly two read requests (0x10, 0x11).
   - ram_wr_en_o stays 0 throughout; done_o pulses once.
3. Start with len 0 in either mode -> done_o pulses the next cycle; busy_o stays 0; no RAM enable and no stream handshake.
4. Load, base 255 (Words 256), len 8 -> four writes to address 255, then four writes to address 0, lanes 0..3 each.
5. Reset asserted in SEND mid-word -> next cycle: state IDLE, out_valid_o = 0, busy_o = 0, ram_wr_en_o = 0. A new dump then restarts cleanly from its own base.
6. start_i pulsed during an active load with different base/len -> ignored; the original transfer completes with its latched parameters and a single done_o.
